// File: rtl/pipe_mac_sequencer.sv
// Window-level scheduler for the 2-stage multiply/accumulate pipe; optional stall counter under PIPE_SEQ_PERF_EN.
// Latency: ld_mult at t -> ld_add at t+1 -> out_valid at t+2; done pulses one cycle after the last sum drains.
// Backpressure: out_valid & ~out_ready raises pipe_stall, freezing both stages and all indices until accepted.
module pipe_mac_sequencer #(
    parameter int LEN_W = 4,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [WIN_W-1:0] cfg_wins,
    input  logic             op_valid,
    input  logic             out_ready,
    output logic             ld_mult,
    output logic             ld_add,
    output logic             par_done,
    output logic             pipe_stall,
    output logic [LEN_W-1:0] elem_idx,
    output logic [WIN_W-1:0] win_idx,
    output logic             out_valid,
    output logic             busy,
`ifdef PIPE_SEQ_PERF_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [WIN_W-1:0] wins_q, wins_d;
    logic [LEN_W-1:0] elem_q, elem_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             v1_q, v1_d;
    logic             f1_q, f1_d;
    logic             l1_q, l1_d;
    logic             ov_q, ov_d;
    logic             last_elem;
    logic             last_win;

    assign last_elem = (elem_q == (len_q - LEN_W'(1)));
    assign last_win  = (win_q == (wins_q - WIN_W'(1)));

    always_comb begin
        pipe_stall = ov_q & ~out_ready;
        ld_mult    = (state_q == S_RUN) & op_valid & ~pipe_stall;
        ld_add     = v1_q & ~pipe_stall;
        par_done   = ld_add & f1_q;
        elem_idx   = elem_q;
        win_idx    = win_q;
        out_valid  = ov_q;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_FINISH);
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wins_d  = wins_q;
        elem_d  = elem_q;
        win_d   = win_q;
        v1_d    = v1_q;
        f1_d    = f1_q;
        l1_d    = l1_q;
        ov_d    = ov_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = cfg_len;
                    wins_d  = cfg_wins;
                    elem_d  = '0;
                    win_d   = '0;
                    // An empty run still reports completion through FINISH.
                    state_d = ((cfg_len != '0) && (cfg_wins != '0)) ? S_RUN : S_FINISH;
                end
            end
            S_RUN: begin
                if (ld_mult && last_elem && last_win) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!v1_q && (!ov_q || out_ready)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The final window leaves win_idx parked on wins-1.
        if (ld_mult) begin
            if (last_elem) begin
                elem_d = '0;
                if (!last_win) begin
                    win_d = win_q + WIN_W'(1);
                end
            end else begin
                elem_d = elem_q + LEN_W'(1);
            end
        end

        if (ld_mult) begin
            v1_d = 1'b1;
            f1_d = (elem_q == '0);
            l1_d = last_elem;
        end else if (ld_add) begin
            v1_d = 1'b0;
        end

        if (ld_add && l1_q) begin
            ov_d = 1'b1;
        end else if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            wins_q  <= '0;
            elem_q  <= '0;
            win_q   <= '0;
            v1_q    <= 1'b0;
            f1_q    <= 1'b0;
            l1_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wins_q  <= wins_d;
            elem_q  <= elem_d;
            win_q   <= win_d;
            v1_q    <= v1_d;
            f1_q    <= f1_d;
            l1_q    <= l1_d;
            ov_q    <= ov_d;
        end
    end

`ifdef PIPE_SEQ_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && start) begin
            stall_cnt_d = '0;
        end else if (busy && pipe_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
